// File: rtl/rock_search_ctrl.sv
// Hill-climbing amplitude/frequency search controller for the rocking actuator.
// Optional feedback watchdog enabled by defining ROCK_WATCHDOG_EN.
module rock_search_ctrl #(
    parameter int AW             = 3,
    parameter int FW             = 3,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int MAX_FAIL       = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          stress_valid,
    input  logic          stress_dec,
    output logic [AW-1:0] A,
    output logic [FW-1:0] F,
    output logic          locked,
    output logic          err
);
    localparam int FCW = $clog2(MAX_FAIL + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3
`ifdef ROCK_WATCHDOG_EN
        , ST_ERROR = 3'd4
`endif
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   a_reg, a_next;
    logic [FW-1:0]   f_reg, f_next;
    logic            axis_f_reg, axis_f_next;
    logic            dir_up_reg, dir_up_next;
    logic [FCW-1:0]  fail_cnt_reg, fail_cnt_next;
    logic [FCW-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [SCW-1:0]  settle_cnt_reg, settle_cnt_next;

`ifdef ROCK_WATCHDOG_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCW-1:0]  wd_cnt_reg, wd_cnt_next;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Clamped neighbours of each code: never wrap, never drop below 1.
    logic [AW-1:0] a_up, a_dn;
    logic [FW-1:0] f_up, f_dn;
    logic [FCW-1:0] fail_inc, hold_inc;

    assign a_up     = (a_reg == '1) ? a_reg : a_reg + 1'b1;
    assign a_dn     = (a_reg <= AW'(1)) ? a_reg : a_reg - 1'b1;
    assign f_up     = (f_reg == '1) ? f_reg : f_reg + 1'b1;
    assign f_dn     = (f_reg <= FW'(1)) ? f_reg : f_reg - 1'b1;
    assign fail_inc = fail_cnt_reg + 1'b1;
    assign hold_inc = hold_cnt_reg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            a_reg          <= '0;
            f_reg          <= '0;
            axis_f_reg     <= 1'b1;
            dir_up_reg     <= 1'b1;
            fail_cnt_reg   <= '0;
            hold_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
`ifdef ROCK_WATCHDOG_EN
            wd_cnt_reg     <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            a_reg          <= a_next;
            f_reg          <= f_next;
            axis_f_reg     <= axis_f_next;
            dir_up_reg     <= dir_up_next;
            fail_cnt_reg   <= fail_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
`ifdef ROCK_WATCHDOG_EN
            wd_cnt_reg     <= wd_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        a_next          = a_reg;
        f_next          = f_reg;
        axis_f_next     = axis_f_reg;
        dir_up_next     = dir_up_reg;
        fail_cnt_next   = fail_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
`ifdef ROCK_WATCHDOG_EN
        wd_cnt_next     = wd_cnt_reg;
`endif
        if (!enable) begin
            state_next      = ST_IDLE;
            a_next          = '0;
            f_next          = '0;
            axis_f_next     = 1'b1;
            dir_up_next     = 1'b1;
            fail_cnt_next   = '0;
            hold_cnt_next   = '0;
            settle_cnt_next = '0;
`ifdef ROCK_WATCHDOG_EN
            wd_cnt_next     = '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next    = ST_SETTLE;
                    a_next        = AW'(1);
                    f_next        = FW'(1);
                    axis_f_next   = 1'b1;
                    dir_up_next   = 1'b1;
                    fail_cnt_next = '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt_reg == SCW'(SETTLE_CYCLES - 1)) begin
                        state_next      = ST_WAIT;
                        settle_cnt_next = '0;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (stress_valid) begin
                        state_next = ST_SETTLE;
                        if (stress_dec) begin
                            fail_cnt_next = '0;
                            if (axis_f_reg) f_next = dir_up_reg ? f_up : f_dn;
                            else            a_next = dir_up_reg ? a_up : a_dn;
                        end else if (fail_inc < FCW'(MAX_FAIL)) begin
                            // Reverse and probe the other side of the current point.
                            fail_cnt_next = fail_inc;
                            dir_up_next   = ~dir_up_reg;
                            if (axis_f_reg) f_next = dir_up_reg ? f_dn : f_up;
                            else            a_next = dir_up_reg ? a_dn : a_up;
                        end else if (axis_f_reg) begin
                            axis_f_next   = 1'b0;
                            dir_up_next   = 1'b1;
                            fail_cnt_next = '0;
                            a_next        = a_up;
                        end else begin
                            state_next    = ST_HOLD;
                            fail_cnt_next = '0;
                            hold_cnt_next = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (stress_valid) begin
                        if (stress_dec) begin
                            hold_cnt_next = '0;
                        end else if (hold_inc == FCW'(MAX_FAIL)) begin
                            state_next    = ST_SETTLE;
                            axis_f_next   = 1'b1;
                            dir_up_next   = 1'b1;
                            fail_cnt_next = '0;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_inc;
                        end
                    end
                end
`ifdef ROCK_WATCHDOG_EN
                ST_ERROR: begin
                    a_next = '0;
                    f_next = '0;
                end
`endif
                default: state_next = ST_IDLE;
            endcase
`ifdef ROCK_WATCHDOG_EN
            // Silence in WAIT/HOLD overrides the search; any exit clears the count.
            if (state_reg == ST_WAIT || state_reg == ST_HOLD) begin
                if (stress_valid) begin
                    wd_cnt_next = '0;
                end else if (wd_cnt_reg == WCW'(TIMEOUT_CYCLES)) begin
                    state_next  = ST_ERROR;
                    a_next      = '0;
                    f_next      = '0;
                    wd_cnt_next = '0;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
                if (state_next != state_reg) wd_cnt_next = '0;
            end else begin
                wd_cnt_next = '0;
            end
`endif
        end
    end

    always_comb begin
        A      = a_reg;
        F      = f_reg;
        locked = (state_reg == ST_HOLD);
`ifdef ROCK_WATCHDOG_EN
        err    = (state_reg == ST_ERROR);
`else
        err    = 1'b0;
`endif
    end

endmodule
